// File: rtl/tsic_cmd_framer.sv
// Byte/word framing between the UART transceiver and TSIC_cntrl: 2-byte RX command
// assembly with inter-byte timeout, 2-byte TX response split. Define TSIC_FRAME_CHKSUM_EN for 3-byte XOR-checked frames.
module tsic_cmd_framer #(
    parameter int TO_CYCLES = 5000,
    parameter int TO_W      = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [15:0] resp,
    input  logic        snd_resp,
    output logic        resp_busy,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_LO   = 2'd1;
    localparam logic [1:0] RX_CK   = 2'd2;

    localparam logic [2:0] TX_IDLE = 3'd0;
    localparam logic [2:0] TX_HI   = 3'd1;
    localparam logic [2:0] TX_WHI  = 3'd2;
    localparam logic [2:0] TX_LO   = 3'd3;
    localparam logic [2:0] TX_WLO  = 3'd4;
    localparam logic [2:0] TX_CK   = 3'd5;
    localparam logic [2:0] TX_WCK  = 3'd6;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ZERO = TO_W'(0);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

`ifdef TSIC_FRAME_CHKSUM_EN
    function automatic logic [7:0] frame_chk(input logic [7:0] hi, input logic [7:0] lo);
        frame_chk = hi ^ lo;
    endfunction
`endif

    logic [1:0]      rx_state_r;
    logic [1:0]      rx_state_nxt_s;
    logic [TO_W-1:0] timer_r;
    logic [TO_W-1:0] timer_nxt_s;
    logic [7:0]      hi_r;
    logic            hi_ld_s;
    logic            frame_done_s;
    logic            frame_drop_s;
    logic [15:0]     cmd_nxt_s;
    logic [15:0]     cmd_r;
    logic            cmd_rdy_r;
    logic            frame_err_r;
    logic            overrun_r;
`ifdef TSIC_FRAME_CHKSUM_EN
    logic [7:0]      lo_r;
    logic            lo_ld_s;
`endif

    logic [2:0]      tx_state_r;
    logic [2:0]      tx_state_nxt_s;
    logic [15:0]     resp_r;
    logic            resp_ld_s;
    logic            send_s;
    logic [7:0]      send_byte_s;
    logic            busy_clr_s;
    logic            resp_busy_r;
    logic [7:0]      tx_data_r;
    logic            trmt_r;

    // RX next-state: a byte arriving on the timeout cycle still counts.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        timer_nxt_s    = timer_r;
        hi_ld_s        = 1'b0;
        frame_done_s   = 1'b0;
        frame_drop_s   = 1'b0;
`ifdef TSIC_FRAME_CHKSUM_EN
        lo_ld_s        = 1'b0;
        cmd_nxt_s      = {hi_r, lo_r};
`else
        cmd_nxt_s      = {hi_r, rx_data};
`endif
        case (rx_state_r)
            RX_IDLE: begin
                timer_nxt_s = TO_ZERO;
                if (rx_rdy) begin
                    hi_ld_s        = 1'b1;
                    rx_state_nxt_s = RX_LO;
                end else begin
                    rx_state_nxt_s = RX_IDLE;
                end
            end
            RX_LO: begin
                if (rx_rdy) begin
                    timer_nxt_s = TO_ZERO;
`ifdef TSIC_FRAME_CHKSUM_EN
                    lo_ld_s        = 1'b1;
                    rx_state_nxt_s = RX_CK;
`else
                    frame_done_s   = 1'b1;
                    rx_state_nxt_s = RX_IDLE;
`endif
                end else if (timer_r == TO_LAST) begin
                    frame_drop_s   = 1'b1;
                    timer_nxt_s    = TO_ZERO;
                    rx_state_nxt_s = RX_IDLE;
                end else begin
                    timer_nxt_s = timer_r + TO_ONE;
                end
            end
`ifdef TSIC_FRAME_CHKSUM_EN
            RX_CK: begin
                if (rx_rdy) begin
                    timer_nxt_s    = TO_ZERO;
                    rx_state_nxt_s = RX_IDLE;
                    if (rx_data == frame_chk(hi_r, lo_r)) begin
                        frame_done_s = 1'b1;
                    end else begin
                        frame_drop_s = 1'b1;
                    end
                end else if (timer_r == TO_LAST) begin
                    frame_drop_s   = 1'b1;
                    timer_nxt_s    = TO_ZERO;
                    rx_state_nxt_s = RX_IDLE;
                end else begin
                    timer_nxt_s = timer_r + TO_ONE;
                end
            end
`endif
            default: begin
                timer_nxt_s    = TO_ZERO;
                rx_state_nxt_s = RX_IDLE;
            end
        endcase
    end

    // RX state, command register and status pulses; completion beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r  <= RX_IDLE;
            timer_r     <= TO_ZERO;
            hi_r        <= 8'h00;
            cmd_r       <= 16'h0000;
            cmd_rdy_r   <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef TSIC_FRAME_CHKSUM_EN
            lo_r        <= 8'h00;
`endif
        end else begin
            rx_state_r  <= rx_state_nxt_s;
            timer_r     <= timer_nxt_s;
            frame_err_r <= frame_drop_s;
            overrun_r   <= frame_done_s & cmd_rdy_r & ~clr_cmd_rdy;
            if (hi_ld_s) begin
                hi_r <= rx_data;
            end
`ifdef TSIC_FRAME_CHKSUM_EN
            if (lo_ld_s) begin
                lo_r <= rx_data;
            end
`endif
            if (frame_done_s) begin
                cmd_r     <= cmd_nxt_s;
                cmd_rdy_r <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy_r <= 1'b0;
            end
        end
    end

    // TX next-state: each byte is launched on the edge that enters its send state.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        resp_ld_s      = 1'b0;
        send_s         = 1'b0;
        send_byte_s    = 8'h00;
        busy_clr_s     = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (snd_resp) begin
                    resp_ld_s      = 1'b1;
                    send_s         = 1'b1;
                    send_byte_s    = resp[15:8];
                    tx_state_nxt_s = TX_HI;
                end else begin
                    tx_state_nxt_s = TX_IDLE;
                end
            end
            TX_HI: begin
                tx_state_nxt_s = TX_WHI;
            end
            TX_WHI: begin
                if (tx_done) begin
                    send_s         = 1'b1;
                    send_byte_s    = resp_r[7:0];
                    tx_state_nxt_s = TX_LO;
                end else begin
                    tx_state_nxt_s = TX_WHI;
                end
            end
            TX_LO: begin
                tx_state_nxt_s = TX_WLO;
            end
            TX_WLO: begin
                if (tx_done) begin
`ifdef TSIC_FRAME_CHKSUM_EN
                    send_s         = 1'b1;
                    send_byte_s    = frame_chk(resp_r[15:8], resp_r[7:0]);
                    tx_state_nxt_s = TX_CK;
`else
                    busy_clr_s     = 1'b1;
                    tx_state_nxt_s = TX_IDLE;
`endif
                end else begin
                    tx_state_nxt_s = TX_WLO;
                end
            end
`ifdef TSIC_FRAME_CHKSUM_EN
            TX_CK: begin
                tx_state_nxt_s = TX_WCK;
            end
            TX_WCK: begin
                if (tx_done) begin
                    busy_clr_s     = 1'b1;
                    tx_state_nxt_s = TX_IDLE;
                end else begin
                    tx_state_nxt_s = TX_WCK;
                end
            end
`endif
            default: begin
                tx_state_nxt_s = TX_IDLE;
            end
        endcase
    end

    // TX state, latched response word and UART transmitter handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r  <= TX_IDLE;
            resp_r      <= 16'h0000;
            resp_busy_r <= 1'b0;
            tx_data_r   <= 8'h00;
            trmt_r      <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            trmt_r     <= send_s;
            if (resp_ld_s) begin
                resp_r <= resp;
            end
            if (send_s) begin
                tx_data_r <= send_byte_s;
            end
            if (resp_ld_s) begin
                resp_busy_r <= 1'b1;
            end else if (busy_clr_s) begin
                resp_busy_r <= 1'b0;
            end
        end
    end

    assign cmd       = cmd_r;
    assign cmd_rdy   = cmd_rdy_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign resp_busy = resp_busy_r;
    assign tx_data   = tx_data_r;
    assign trmt      = trmt_r;

    tsic_cmd_framer_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .trmt      (trmt_r),
        .resp_busy (resp_busy_r),
        .frame_err (frame_err_r),
        .overrun   (overrun_r),
        .cmd_rdy   (cmd_rdy_r)
    );

endmodule

// Output-relationship invariants of the framer.
module tsic_cmd_framer_chk (
    input logic clk,
    input logic rst,
    input logic trmt,
    input logic resp_busy,
    input logic frame_err,
    input logic overrun,
    input logic cmd_rdy
);

    a_trmt_in_busy: assert property (@(posedge clk) disable iff (rst) trmt |-> resp_busy);
    a_trmt_pulse:   assert property (@(posedge clk) disable iff (rst) trmt |=> !trmt);
    a_ovr_has_cmd:  assert property (@(posedge clk) disable iff (rst) overrun |-> cmd_rdy);
    a_err_xor_ovr:  assert property (@(posedge clk) disable iff (rst) !(frame_err && overrun));

endmodule
